// File: rtl/sram_responder.sv
// SRAM stand-in for the pin-level test interface: oversamples s_clk, services
// writes/reads on an internal array, counts accesses and flags protocol errors.
module sram_responder #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] INIT_PATTERN = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_clk,
    input  logic              s_cen,
    input  logic              s_wen,
    input  logic              s_oen,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_ddata,
    output logic [DATA_W-1:0] s_qdata,
    input  logic              err_clr,
    output logic              busy,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              protocol_err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_IDLE} state_e;

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] cen_q, cen_d;
    logic [SYNC_STAGES-1:0] wen_q, wen_d;
    logic [SYNC_STAGES-1:0] oen_q, oen_d;
    logic [SYNC_STAGES-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] ddata_q, ddata_d;
    logic prev_q, prev_d;

    logic sclk_s, cen_s, wen_s, oen_s, rise;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] ddata_s;

    state_e state_q, state_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic err_q, err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic wr_inc, rd_inc, err_set;

    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign cen_s   = cen_q[SYNC_STAGES-1];
    assign wen_s   = wen_q[SYNC_STAGES-1];
    assign oen_s   = oen_q[SYNC_STAGES-1];
    assign addr_s  = addr_q[SYNC_STAGES-1];
    assign ddata_s = ddata_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~prev_q;

    always_comb begin
        sclk_d  = {sclk_q[SYNC_STAGES-2:0], s_clk};
        cen_d   = {cen_q[SYNC_STAGES-2:0], s_cen};
        wen_d   = {wen_q[SYNC_STAGES-2:0], s_wen};
        oen_d   = {oen_q[SYNC_STAGES-2:0], s_oen};
        addr_d  = {addr_q[SYNC_STAGES-2:0], s_addr};
        ddata_d = {ddata_q[SYNC_STAGES-2:0], s_ddata};
        prev_d  = sclk_s;
    end

    // s_clk history resets high so a pin already high never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q  <= '1;
            cen_q   <= '1;
            wen_q   <= '1;
            oen_q   <= '1;
            addr_q  <= '0;
            ddata_q <= '0;
            prev_q  <= 1'b1;
        end else begin
            sclk_q  <= sclk_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            addr_q  <= addr_d;
            ddata_q <= ddata_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_waddr   = addr_s;
        mem_wdata   = ddata_s;
        wr_inc      = 1'b0;
        rd_inc      = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            ST_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_addr_q;
                mem_wdata   = INIT_PATTERN;
                init_addr_d = init_addr_q + ADDR_W'(1);
                err_set     = rise;
                if (init_addr_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise && !cen_s) begin
                    if (!wen_s) begin
                        mem_we = 1'b1;
                        wr_inc = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_s];
                        rd_inc  = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
        wr_count_d = (wr_inc && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
        rd_count_d = (rd_inc && rd_count_q != 16'hFFFF) ? rd_count_q + 16'd1 : rd_count_q;
        err_d      = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
            rdata_q     <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            rdata_q     <= rdata_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    assign s_qdata      = oen_s ? '0 : rdata_q;
    assign busy         = (state_q == ST_INIT);
    assign wr_count     = wr_count_q;
    assign rd_count     = rd_count_q;
    assign protocol_err = err_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: pin-level accesses driven on the falling
// clock edge, outputs sampled on the falling edge against hand-computed values.
module tb_sram_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        s_clk, s_cen, s_wen, s_oen;
    logic [4:0]  s_addr;
    logic [7:0]  s_ddata, s_qdata;
    logic        err_clr, busy, protocol_err;
    logic [15:0] wr_count, rd_count;

    int total = 0;
    int bad   = 0;
    int n;

    sram_responder dut (
        .clk(clk), .reset(reset), .s_clk(s_clk), .s_cen(s_cen),
        .s_wen(s_wen), .s_oen(s_oen), .s_addr(s_addr), .s_ddata(s_ddata),
        .s_qdata(s_qdata), .err_clr(err_clr), .busy(busy),
        .wr_count(wr_count), .rd_count(rd_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // leaves s_clk high; the caller sits 4 cycles after the pin rise
    task automatic pin_rise(input logic cen, input logic wen,
                            input logic [4:0] a, input logic [7:0] d);
        s_cen = cen; s_wen = wen; s_addr = a; s_ddata = d;
        tick(4);
        s_clk = 1'b1;
        tick(4);
    endtask

    task automatic pin_fall();
        s_clk = 1'b0;
        tick(4);
        s_cen = 1'b1; s_wen = 1'b1;
        tick(1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            tick(1);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; s_clk = 1'b0; s_cen = 1'b1; s_wen = 1'b1; s_oen = 1'b1;
        s_addr = '0; s_ddata = '0; err_clr = 1'b0;
        tick(3);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_wr", {16'd0, wr_count}, 32'd0);
        chk("rst_rd", {16'd0, rd_count}, 32'd0);
        chk("rst_err", {31'd0, protocol_err}, 32'd0);
        chk("rst_q", {24'd0, s_qdata}, 32'd0);

        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick(1);
        end
        chk("busy_len", n, 32'd32);

        s_oen = 1'b0;
        tick(3);
        pin_rise(1'b0, 1'b1, 5'd5, 8'h00);
        chk("rd5", {24'd0, s_qdata}, 32'h00);
        pin_fall();
        chk("rd5_cnt", {16'd0, rd_count}, 32'd1);

        pin_rise(1'b0, 1'b0, 5'd3, 8'hA5); pin_fall();
        pin_rise(1'b0, 1'b0, 5'd31, 8'h3C); pin_fall();
        pin_rise(1'b0, 1'b1, 5'd3, 8'h00);
        chk("rd3", {24'd0, s_qdata}, 32'hA5);
        pin_fall();
        pin_rise(1'b0, 1'b1, 5'd31, 8'h00);
        chk("rd31", {24'd0, s_qdata}, 32'h3C);
        pin_fall();
        chk("wr_cnt2", {16'd0, wr_count}, 32'd2);
        chk("rd_cnt3", {16'd0, rd_count}, 32'd3);

        s_oen = 1'b1;
        tick(3);
        pin_rise(1'b0, 1'b1, 5'd3, 8'h00);
        chk("oen_hi", {24'd0, s_qdata}, 32'h00);
        pin_fall();
        s_oen = 1'b0;
        tick(2);
        chk("oen_lo", {24'd0, s_qdata}, 32'hA5);

        pin_rise(1'b1, 1'b0, 5'd3, 8'hFF); pin_fall();
        pin_rise(1'b1, 1'b1, 5'd31, 8'h00); pin_fall();
        chk("cen_hold_q", {24'd0, s_qdata}, 32'hA5);
        chk("cen_wr", {16'd0, wr_count}, 32'd2);
        chk("cen_rd", {16'd0, rd_count}, 32'd4);
        pin_rise(1'b0, 1'b1, 5'd31, 8'h00); pin_fall();
        pin_rise(1'b0, 1'b1, 5'd3, 8'h00);
        chk("cen_arr", {24'd0, s_qdata}, 32'hA5);
        pin_fall();

        reset = 1'b1; tick(2); reset = 1'b0;
        tick(2);
        s_cen = 1'b0; s_wen = 1'b0; s_addr = 5'd7; s_ddata = 8'h55;
        s_clk = 1'b1;
        tick(4);
        chk("init_err", {31'd0, protocol_err}, 32'd1);
        chk("init_wr", {16'd0, wr_count}, 32'd0);
        pin_fall();
        wait_idle("idle1");
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("err_clr", {31'd0, protocol_err}, 32'd0);

        reset = 1'b1; tick(2); reset = 1'b0;
        tick(2);
        s_clk = 1'b1;
        tick(2);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("set_wins", {31'd0, protocol_err}, 32'd1);
        pin_fall();
        wait_idle("idle2");

        force dut.wr_count_q = 16'hFFFD;
        tick(1);
        release dut.wr_count_q;
        pin_rise(1'b0, 1'b0, 5'd3, 8'h77); pin_fall();
        chk("sat1", {16'd0, wr_count}, 32'hFFFE);
        pin_rise(1'b0, 1'b0, 5'd3, 8'h77); pin_fall();
        chk("sat2", {16'd0, wr_count}, 32'hFFFF);
        pin_rise(1'b0, 1'b0, 5'd3, 8'h77); pin_fall();
        chk("sat3", {16'd0, wr_count}, 32'hFFFF);

        reset = 1'b1; tick(1);
        chk("mid_wr", {16'd0, wr_count}, 32'd0);
        chk("mid_rd", {16'd0, rd_count}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        wait_idle("idle3");
        pin_rise(1'b0, 1'b1, 5'd3, 8'h00);
        chk("mid_rd3", {24'd0, s_qdata}, 32'h00);
        pin_fall();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
